// File: rtl/local_inject_arb.sv
// Round-robin arbiter that merges N_REQ local injectors into one registered
// flit slot feeding the router local input port.

`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module local_inject_arb #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned FLIT_W = `HDR_SZ + `PL_SZ + `ADDR_SZ
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*FLIT_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_busy,
    output logic [FLIT_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic [19:0]               flit_counter
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = 20;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  win_id_c;
    logic [ID_W-1:0]  next_ptr_c;
    logic             win_found_c;
    logic             slot_free_c;
    logic             up_c;
    logic             down_c;
    logic [CNT_W-1:0] cnt_q;
    int unsigned      idx;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found_c = 1'b0;
        win_id_c    = '0;
        idx         = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!win_found_c && req_valid[ID_W'(idx)]) begin
                win_found_c = 1'b1;
                win_id_c    = ID_W'(idx);
            end
        end
    end

    // Handshake qualification; reset gating keeps every busy bit high in reset.
    always_comb begin
        slot_free_c = !out_valid || !out_busy;
        up_c        = win_found_c && en && reset && slot_free_c;
        down_c      = out_valid && !out_busy;
        next_ptr_c  = (win_id_c == ID_W'(N_REQ - 1)) ? '0 : ID_W'(win_id_c + ID_W'(1));
        req_busy    = '1;
        if (up_c) begin
            req_busy[win_id_c] = 1'b0;
        end
    end

    // One-flit output register; a fill in the same edge as a drain wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            grant_id  <= '0;
            rr_ptr    <= '0;
            cnt_q     <= '0;
        end else begin
            if (up_c) begin
                out_data  <= req_data[32'(win_id_c) * FLIT_W +: FLIT_W];
                grant_id  <= win_id_c;
                out_valid <= 1'b1;
                rr_ptr    <= next_ptr_c;
            end else if (down_c) begin
                out_valid <= 1'b0;
            end
            if (down_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign flit_counter = cnt_q;

endmodule

// File: tb/tb_local_inject_arb.sv
// Bench for local_inject_arb: directed scenarios plus random traffic, all
// checked against a cycle-level reference model of the arbitration rules.

module tb_local_inject_arb;

    localparam int N  = 4;
    localparam int FW = 16;

    logic            clk;
    logic            reset;
    logic            en;
    logic [N-1:0]    req_valid;
    logic [N*FW-1:0] req_data;
    logic [N-1:0]    req_busy;
    logic [FW-1:0]   out_data;
    logic            out_valid;
    logic            out_busy;
    logic [1:0]      grant_id;
    logic [19:0]     flit_counter;

    int compared;
    int mismatched;

    // reference model state
    bit          m_valid;
    logic [FW-1:0] m_data;
    int          m_id;
    int          m_ptr;
    int unsigned m_cnt;

    local_inject_arb #(.N_REQ(N), .FLIT_W(FW)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_busy     (req_busy),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_busy     (out_busy),
        .grant_id     (grant_id),
        .flit_counter (flit_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int find_winner();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    // Check outputs against the model, advance one clock, update the model.
    task automatic step();
        int w;
        bit up;
        bit down;
        logic [N-1:0] exp_busy;
        #1;
        w = find_winner();
        exp_busy = '1;
        if (w >= 0 && en && reset && (!m_valid || !out_busy)) exp_busy[w] = 1'b0;
        check("req_busy", 32'(req_busy), 32'(exp_busy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("grant_id", 32'(grant_id), 32'(m_id));
        check("flit_counter", 32'(flit_counter), m_cnt);
        @(posedge clk);
        if (reset) begin
            up   = (w >= 0) && en && (!m_valid || !out_busy);
            down = m_valid && !out_busy;
            if (down) m_cnt = (m_cnt + 1) & 32'hFFFFF;
            if (up) begin
                m_data  = req_data[w*FW +: FW];
                m_id    = w;
                m_valid = 1'b1;
                m_ptr   = (w + 1) % N;
            end else if (down) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_data();
        for (int i = 0; i < N; i++) req_data[i*FW +: FW] = FW'(16'h1000 * (i + 1) + $urandom_range(0, 255));
    endtask

    initial begin
        int exp_ids[5];
        compared   = 0;
        mismatched = 0;
        model_reset();
        reset     = 1'b0;
        en        = 1'b1;
        out_busy  = 1'b0;
        req_valid = '1;
        set_data();

        // reset values hold before any clock edge
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_flit_counter", 32'(flit_counter), 32'd0);
        check("rst_req_busy", 32'(req_busy), 32'hF);

        // all requesters active: grants rotate 0,1,2,3,0
        @(negedge clk);
        reset = 1'b1;
        exp_ids = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_seq_id", 32'(grant_id), 32'(exp_ids[i]));
            check("rr_seq_valid", 32'(out_valid), 32'd1);
        end
        req_valid = '0;
        step();
        check("five_drains", 32'(flit_counter), 32'd5);

        // single requester with downstream stall
        step();
        req_valid = 4'b0100;
        req_data[2*FW +: FW] = 16'h00A5;
        out_busy  = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_busy", 32'(req_busy), 32'hF);
            check("stall_data", 32'(out_data), 32'h00A5);
            check("stall_valid", 32'(out_valid), 32'd1);
            step();
        end
        out_busy  = 1'b0;
        req_valid = '0;
        step();
        check("stall_drained", 32'(flit_counter), 32'd6);
        check("stall_drained_valid", 32'(out_valid), 32'd0);

        // drain and accept in the same edge
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0010;
        #1;
        check("no_bubble_busy", 32'(req_busy), 32'hD);
        step();
        check("no_bubble_valid", 32'(out_valid), 32'd1);
        check("no_bubble_data", 32'(out_data), 32'(req_data[1*FW +: FW]));

        // en=0 lets the held flit drain but blocks new grants
        req_valid = '1;
        en = 1'b0;
        step();
        check("en0_drain_valid", 32'(out_valid), 32'd0);
        en = 1'b1;
        step();
        check("en1_resume_id", 32'(grant_id), 32'd2);

        // asynchronous reset while a flit is held
        out_busy = 1'b1;
        step();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_counter", 32'(flit_counter), 32'd0);
        model_reset();
        @(negedge clk);
        reset    = 1'b1;
        out_busy = 1'b0;
        step();
        check("post_rst_first_id", 32'(grant_id), 32'd0);

        // counter wrap from preloaded all-ones
        req_valid = '0;
        force dut.cnt_q = 20'hFFFFF;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFFF;
        step();
        check("wrap_counter", 32'(flit_counter), 32'd0);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom_range(0, 15));
            en        = ($urandom_range(0, 9) < 8);
            out_busy  = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 3) == 0) set_data();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
